ram_port_requester: RTL and testbench
=====================================

// Module: ram_port_requester
// PURPOSE
// Request-side controller for one port of the common-clock true dual-port RAM (fixed read latency, no_change write mode).
// Accepts read/write requests on a valid/ready stream, drives the RAM port, and captures read data in order into a credit-reserved response FIFO.
// Read data is never lost under downstream backpressure. One instance per RAM port; sits between packet/message logic and the RAM.
// PARAMETERS
// DATA_WIDTH    32                   word width; must match the RAM
// NUM_ENTRIES   2048                 RAM depth
// ADDR_WIDTH    $clog2(NUM_ENTRIES)  address width
// READ_LATENCY  1                    RAM read latency in cycles, >=1; must match the RAM
// RESP_DEPTH    4                    response FIFO entries, >=1; >=READ_LATENCY+1 gives full read throughput
// PORTS
// clock       in   1           single clock
// reset_n     in   1           asynchronous, active-low reset
// req_valid   in   1           request valid
// req_ready   out  1           request accepted when valid&&ready
// req_write   in   1           1=write, 0=read
// req_addr    in   ADDR_WIDTH  word address
// req_data    in   DATA_WIDTH  write data; ignored for reads
// resp_valid  out  1           read data valid
// resp_ready  in   1           downstream accepts resp_data
// resp_data   out  DATA_WIDTH  read data, in request order
// ram_addr    out  ADDR_WIDTH  to RAM port addr
// ram_we      out  1           to RAM port we
// ram_din     out  DATA_WIDTH  to RAM port din
// ram_dout    in   DATA_WIDTH  from RAM port dout
// BEHAVIOUR
// - Reset (reset_n low, async): in-flight pipe cleared, FIFO emptied, credits=RESP_DEPTH. req_ready=0, resp_valid=0, ram_we=0 while reset_n low.
// - credits = RESP_DEPTH - (reads in flight + FIFO occupancy). Registered and updated every cycle.
// - req_ready = reset_n && (req_write || credits>0). Writes are never back-pressured. Reads need one free credit.
// - Accept: ram_addr=req_addr, ram_din=req_data, ram_we=req_valid&&req_ready&&req_write. Combinational, same cycle.
// - With no request, ram_addr holds its last value, and ram_din and ram_we are 0.
// - Writes produce no response.
// - Read accepted in cycle t: a valid bit enters a READ_LATENCY-deep shift pipe, credit decremented.
//   In cycle t+READ_LATENCY, ram_dout is pushed into the FIFO.
//   resp_valid is high from cycle t+READ_LATENCY+1 (2 cycles for READ_LATENCY=1).
// - resp_valid = FIFO non-empty; resp_data = FIFO head. Pop on resp_valid&&resp_ready, which returns one credit next cycle.
// - Same-cycle pop and read accept: net credit change is 0. Accepting at credits==1 with a pop in that cycle is allowed.
// - FIFO can never overflow because of credit reservation. A push with the FIFO full is an assertion failure.
// - Full throughput: with resp_ready=1 and RESP_DEPTH>=READ_LATENCY+1, one read per cycle is sustained indefinitely.
// - Read-after-write to the same address in consecutive cycles returns the new data (RAM ordering). Interleaved R/W keeps read order.
// - Reset mid-operation: in-flight reads and buffered data are discarded; nothing is emitted after reset_n rises.
// - Stability: resp_data/resp_valid hold while resp_valid&&!resp_ready.
// STRUCTURE
// - Shared package lnic_ram_pkg: req_t struct {write, addr, data} and the localparam for the default READ_LATENCY.
// - Sub-module ram_resp_fifo: sync FIFO (DATA_WIDTH x RESP_DEPTH) with async active-low reset, push/pop, full/empty/count.
// - Top level holds credit counter, valid shift pipe and the RAM-port drive.
// TESTING
// - Reset: reset_n low mid-burst of 3 reads -> resp_valid=0, req_ready=0; after release, credits=4 and no stale response.
// - Write 0xDEADBEEF @0x010, then read @0x010 next cycle -> resp_data=0xDEADBEEF exactly 2 cycles after the read is accepted.
// - Streaming: reads @0..15 back-to-back, resp_ready=1 -> req_ready stays 1; responses are data 0..15 in order, one per cycle.
// - Backpressure: resp_ready=0, issue reads -> exactly 4 accepted, then req_ready=0. Writes are still accepted.
//   Raising resp_ready drains 4 in order, and req_ready reasserts the cycle after the first pop.
// - Boundary: credits==1 with a pop and a read in the same cycle -> read accepted, credits stays 1, FIFO never exceeds 4.
// - Random R/W mix against a reference model, random resp_ready -> all read data match, order preserved, no overflow assertions.

Source files
------------

// File: rtl/lnic_ram_pkg.sv
// Shared types and default parameters for the RAM port requester and its users.
package lnic_ram_pkg;

  localparam int DEFAULT_DATA_WIDTH   = 32;
  localparam int DEFAULT_NUM_ENTRIES  = 2048;
  localparam int DEFAULT_ADDR_WIDTH   = $clog2(DEFAULT_NUM_ENTRIES);
  localparam int DEFAULT_READ_LATENCY = 1;
  localparam int DEFAULT_RESP_DEPTH   = 4;

  typedef struct packed {
    logic                          write;
    logic [DEFAULT_ADDR_WIDTH-1:0] addr;
    logic [DEFAULT_DATA_WIDTH-1:0] data;
  } req_t;

endpackage

// File: rtl/ram_resp_fifo.sv
// Synchronous response FIFO holding RAM read data until downstream accepts it.
module ram_resp_fifo #(
  parameter  int DATA_WIDTH = 32,
  parameter  int DEPTH      = 4,
  localparam int PTR_W      = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int CNT_W      = $clog2(DEPTH + 1)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  push_i,
  input  logic [DATA_WIDTH-1:0] push_data_i,
  input  logic                  pop_i,
  output logic [DATA_WIDTH-1:0] pop_data_o,
  output logic                  full_o,
  output logic                  empty_o,
  output logic [CNT_W-1:0]      count_o
);

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0]      wr_ptr_q;
  logic [PTR_W-1:0]      rd_ptr_q;
  logic [CNT_W-1:0]      count_q;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  // NOTE: storage has no reset; the pointers and count alone decide which entries are valid.
  always_ff @(posedge clk) begin
    if (push_i) mem_q[wr_ptr_q] <= push_data_i;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_i) wr_ptr_q <= ptr_inc(wr_ptr_q);
      if (pop_i)  rd_ptr_q <= ptr_inc(rd_ptr_q);
      case ({push_i, pop_i})
        2'b10:   count_q <= count_q + CNT_W'(1);
        2'b01:   count_q <= count_q - CNT_W'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  assign pop_data_o = mem_q[rd_ptr_q];
  assign full_o     = (count_q == CNT_W'(DEPTH));
  assign empty_o    = (count_q == '0);
  assign count_o    = count_q;

  a_no_overflow:  assert property (@(posedge clk) disable iff (!rst_n) push_i |-> !full_o);
  a_no_underflow: assert property (@(posedge clk) disable iff (!rst_n) pop_i |-> !empty_o);

endmodule

// File: rtl/ram_port_requester.sv
// Request side of one RAM port: drives the port, tracks reads in flight and
// reserves a response slot (credit) for every read so read data is never dropped.
module ram_port_requester
  import lnic_ram_pkg::*;
#(
  parameter int DATA_WIDTH   = DEFAULT_DATA_WIDTH,
  parameter int NUM_ENTRIES  = DEFAULT_NUM_ENTRIES,
  parameter int ADDR_WIDTH   = $clog2(NUM_ENTRIES),
  parameter int READ_LATENCY = DEFAULT_READ_LATENCY,
  parameter int RESP_DEPTH   = DEFAULT_RESP_DEPTH
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_write,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0] req_data,
  output logic                  resp_valid,
  input  logic                  resp_ready,
  output logic [DATA_WIDTH-1:0] resp_data,
  output logic [ADDR_WIDTH-1:0] ram_addr,
  output logic                  ram_we,
  output logic [DATA_WIDTH-1:0] ram_din,
  input  logic [DATA_WIDTH-1:0] ram_dout
);

  localparam int CRED_W = $clog2(RESP_DEPTH + 1);

  logic [CRED_W-1:0]       credits_q, credits_d;
  logic [READ_LATENCY-1:0] pipe_q, pipe_d;
  logic [ADDR_WIDTH-1:0]   addr_q;
  logic                    accept, rd_accept, pop;
  logic                    fifo_empty, fifo_full;
  logic [CRED_W-1:0]       fifo_count;

  assign req_ready  = reset_n && (req_write || (credits_q != '0));
  assign accept     = req_valid && req_ready;
  assign rd_accept  = accept && !req_write;
  assign ram_we     = accept && req_write;
  assign ram_din    = accept ? req_data : '0;
  assign ram_addr   = accept ? req_addr : addr_q;
  assign resp_valid = !fifo_empty;
  assign pop        = resp_valid && resp_ready;

  // NOTE: every signal driven here gets a default first, so no latch can be inferred.
  always_comb begin
    credits_d = credits_q;
    if (rd_accept && !pop)      credits_d = credits_q - CRED_W'(1);
    else if (pop && !rd_accept) credits_d = credits_q + CRED_W'(1);
    pipe_d    = pipe_q << 1;
    pipe_d[0] = rd_accept;
  end

  // NOTE: state registers use non-blocking '<=' so all of them update from pre-edge values.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      credits_q <= CRED_W'(RESP_DEPTH);
      pipe_q    <= '0;
      addr_q    <= '0;
    end else begin
      credits_q <= credits_d;
      pipe_q    <= pipe_d;
      if (accept) addr_q <= req_addr;
    end
  end

  // The oldest pipe stage marks the cycle in which ram_dout carries the read data.
  ram_resp_fifo #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (RESP_DEPTH)
  ) u_fifo (
    .clk         (clock),
    .rst_n       (reset_n),
    .push_i      (pipe_q[READ_LATENCY-1]),
    .push_data_i (ram_dout),
    .pop_i       (pop),
    .pop_data_o  (resp_data),
    .full_o      (fifo_full),
    .empty_o     (fifo_empty),
    .count_o     (fifo_count)
  );

  a_credit_conservation: assert property (@(posedge clock) disable iff (!reset_n)
    int'(credits_q) + $countones(pipe_q) + int'(fifo_count) == RESP_DEPTH);
  a_full_means_no_credit: assert property (@(posedge clock) disable iff (!reset_n)
    fifo_full |-> (credits_q == '0));

endmodule

// File: tb/tb_ram_port_requester.sv
// Bench for ram_port_requester: behavioural RAM on the port side and a timed
// queue model of credits, read latency and response order.
module tb_ram_port_requester;
  import lnic_ram_pkg::*;

  localparam int DW    = DEFAULT_DATA_WIDTH;
  localparam int AW    = DEFAULT_ADDR_WIDTH;
  localparam int N     = DEFAULT_NUM_ENTRIES;
  localparam int LAT   = DEFAULT_READ_LATENCY;
  localparam int DEPTH = DEFAULT_RESP_DEPTH;

  logic          clock = 1'b0;
  logic          reset_n = 1'b1;
  logic          req_valid = 1'b0;
  logic          req_ready;
  logic          req_write = 1'b0;
  logic [AW-1:0] req_addr = '0;
  logic [DW-1:0] req_data = '0;
  logic          resp_valid;
  logic          resp_ready = 1'b0;
  logic [DW-1:0] resp_data;
  logic [AW-1:0] ram_addr;
  logic          ram_we;
  logic [DW-1:0] ram_din;
  logic [DW-1:0] ram_dout;

  always #5 clock = ~clock;

  ram_port_requester dut (
    .clock      (clock),
    .reset_n    (reset_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_write  (req_write),
    .req_addr   (req_addr),
    .req_data   (req_data),
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .resp_data  (resp_data),
    .ram_addr   (ram_addr),
    .ram_we     (ram_we),
    .ram_din    (ram_din),
    .ram_dout   (ram_dout)
  );

  // Latency-1, no_change RAM port: output register holds during writes.
  logic [DW-1:0] ram_mem [N];
  always @(posedge clock) begin
    if (ram_we) ram_mem[ram_addr] <= ram_din;
    else        ram_dout <= ram_mem[ram_addr];
  end

  typedef struct {
    int            due;
    logic [DW-1:0] data;
  } pend_t;

  logic [DW-1:0] model_mem [N];
  pend_t         pend_q[$];
  logic [DW-1:0] rfifo_q[$];
  logic [AW-1:0] last_addr;
  int            cyc = 0;
  int            errors = 0;
  int            checks = 0;

  function automatic req_t mk(input logic w, input int a, input logic [DW-1:0] d);
    req_t r;
    r.write = w;
    r.addr  = AW'(a);
    r.data  = d;
    return r;
  endfunction

  task automatic model_reset();
    pend_q.delete();
    rfifo_q.delete();
    last_addr = '0;
  endtask

  // One clock cycle: drive at posedge+1, compare at negedge, advance model, return at next posedge+1.
  task automatic cycle(input logic valid, input req_t r, input logic rdy,
                       output logic obs_acc, output logic obs_pop, output logic [DW-1:0] obs_data);
    logic          exp_ready, exp_rvalid, exp_acc, exp_pop;
    logic [AW-1:0] exp_addr;
    logic [DW-1:0] exp_din;
    pend_t         p;
    req_valid  = valid;
    req_write  = r.write;
    req_addr   = r.addr;
    req_data   = r.data;
    resp_ready = rdy;
    #4;
    exp_ready  = r.write || ((DEPTH - pend_q.size() - rfifo_q.size()) > 0);
    exp_rvalid = (rfifo_q.size() > 0);
    exp_acc    = valid && exp_ready;
    exp_addr   = exp_acc ? r.addr : last_addr;
    exp_din    = exp_acc ? r.data : '0;
    checks++;
    if (req_ready !== exp_ready) begin
      errors++; $display("FAIL req_ready cyc=%0d got=%b exp=%b", cyc, req_ready, exp_ready);
    end
    checks++;
    if (resp_valid !== exp_rvalid) begin
      errors++; $display("FAIL resp_valid cyc=%0d got=%b exp=%b", cyc, resp_valid, exp_rvalid);
    end
    if (exp_rvalid) begin
      checks++;
      if (resp_data !== rfifo_q[0]) begin
        errors++; $display("FAIL resp_data cyc=%0d got=%h exp=%h", cyc, resp_data, rfifo_q[0]);
      end
    end
    checks++;
    if (ram_we !== (exp_acc && r.write)) begin
      errors++; $display("FAIL ram_we cyc=%0d got=%b exp=%b", cyc, ram_we, exp_acc && r.write);
    end
    checks++;
    if (ram_addr !== exp_addr) begin
      errors++; $display("FAIL ram_addr cyc=%0d got=%h exp=%h", cyc, ram_addr, exp_addr);
    end
    checks++;
    if (ram_din !== exp_din) begin
      errors++; $display("FAIL ram_din cyc=%0d got=%h exp=%h", cyc, ram_din, exp_din);
    end
    obs_acc  = valid && req_ready;
    obs_pop  = resp_valid && rdy;
    obs_data = resp_data;
    exp_pop  = exp_rvalid && rdy;
    if (exp_pop) void'(rfifo_q.pop_front());
    while (pend_q.size() > 0 && pend_q[0].due == cyc) begin
      p = pend_q.pop_front();
      rfifo_q.push_back(p.data);
    end
    if (exp_acc && !r.write) pend_q.push_back('{cyc + LAT, model_mem[r.addr]});
    if (exp_acc && r.write)  model_mem[r.addr] = r.data;
    if (exp_acc)             last_addr = r.addr;
    cyc++;
    @(posedge clock);
    #1;
  endtask

  task automatic idle(input int n, input logic rdy);
    logic a, p;
    logic [DW-1:0] d;
    for (int i = 0; i < n; i++) cycle(1'b0, mk(1'b0, 0, '0), rdy, a, p, d);
  endtask

  task automatic test_reset();
    logic a, p;
    logic [DW-1:0] d;
    int n_acc = 0;
    int n_pop = 0;
    req_valid = 1'b1; req_write = 1'b1; resp_ready = 1'b1;
    #1 reset_n = 1'b0;
    #2;
    checks++; if (req_ready !== 1'b0) begin errors++; $display("FAIL reset_req_ready got=%b exp=0", req_ready); end
    checks++; if (resp_valid !== 1'b0) begin errors++; $display("FAIL reset_resp_valid got=%b exp=0", resp_valid); end
    checks++; if (ram_we !== 1'b0) begin errors++; $display("FAIL reset_ram_we got=%b exp=0", ram_we); end
    @(posedge clock); @(posedge clock); #1;
    model_reset();
    reset_n = 1'b1;
    for (int i = 0; i < 3; i++) cycle(1'b1, mk(1'b1, 'h100 + i, 32'hA000_0000 + i), 1'b0, a, p, d);
    for (int i = 0; i < 3; i++) cycle(1'b1, mk(1'b0, 'h100 + i, '0), 1'b0, a, p, d);
    reset_n = 1'b0;
    #1;
    checks++; if (resp_valid !== 1'b0) begin errors++; $display("FAIL midreset_resp_valid got=%b exp=0", resp_valid); end
    checks++; if (req_ready !== 1'b0) begin errors++; $display("FAIL midreset_req_ready got=%b exp=0", req_ready); end
    model_reset();
    @(posedge clock); #1;
    reset_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      cycle(1'b0, mk(1'b0, 0, '0), 1'b1, a, p, d);
      if (p) n_pop++;
    end
    checks++; if (n_pop !== 0) begin errors++; $display("FAIL stale_responses got=%0d exp=0", n_pop); end
    for (int i = 0; i < 6; i++) begin
      cycle(1'b1, mk(1'b0, 'h100, '0), 1'b0, a, p, d);
      if (a) n_acc++;
    end
    checks++; if (n_acc !== DEPTH) begin errors++; $display("FAIL reset_credits got=%0d exp=%0d", n_acc, DEPTH); end
    idle(8, 1'b1);
  endtask

  task automatic test_raw();
    logic a, p;
    logic [DW-1:0] d;
    cycle(1'b1, mk(1'b1, 'h010, 32'hDEADBEEF), 1'b1, a, p, d);
    cycle(1'b1, mk(1'b0, 'h010, '0), 1'b1, a, p, d);
    checks++; if (a !== 1'b1) begin errors++; $display("FAIL raw_accept got=%b exp=1", a); end
    cycle(1'b0, mk(1'b0, 0, '0), 1'b1, a, p, d);
    checks++; if (p !== 1'b0) begin errors++; $display("FAIL raw_early got=%b exp=0", p); end
    cycle(1'b0, mk(1'b0, 0, '0), 1'b1, a, p, d);
    checks++; if (p !== 1'b1) begin errors++; $display("FAIL raw_valid got=%b exp=1", p); end
    checks++; if (d !== 32'hDEADBEEF) begin errors++; $display("FAIL raw_data got=%h exp=deadbeef", d); end
    idle(2, 1'b1);
  endtask

  task automatic test_streaming();
    logic a, p;
    logic [DW-1:0] d;
    logic [DW-1:0] got[$];
    int n_acc = 0;
    int first_pop = -1;
    int last_pop = -1;
    for (int i = 0; i < 16; i++) cycle(1'b1, mk(1'b1, i, DW'(i)), 1'b1, a, p, d);
    for (int i = 0; i < 22; i++) begin
      if (i < 16) cycle(1'b1, mk(1'b0, i, '0), 1'b1, a, p, d);
      else        cycle(1'b0, mk(1'b0, 0, '0), 1'b1, a, p, d);
      if (i < 16 && a) n_acc++;
      if (p) begin
        got.push_back(d);
        if (first_pop < 0) first_pop = i;
        last_pop = i;
      end
    end
    checks++; if (n_acc !== 16) begin errors++; $display("FAIL stream_accepts got=%0d exp=16", n_acc); end
    checks++; if (got.size() !== 16) begin errors++; $display("FAIL stream_count got=%0d exp=16", got.size()); end
    for (int i = 0; i < got.size(); i++) begin
      checks++;
      if (got[i] !== DW'(i)) begin errors++; $display("FAIL stream_order idx=%0d got=%h exp=%h", i, got[i], i); end
    end
    checks++;
    if (last_pop - first_pop !== 15) begin
      errors++; $display("FAIL stream_rate span=%0d exp=15", last_pop - first_pop);
    end
  endtask

  task automatic test_backpressure();
    logic a, p;
    logic [DW-1:0] d;
    int n_acc = 0;
    for (int i = 0; i < 6; i++) begin
      cycle(1'b1, mk(1'b0, i, '0), 1'b0, a, p, d);
      if (a) n_acc++;
    end
    checks++; if (n_acc !== DEPTH) begin errors++; $display("FAIL bp_accepts got=%0d exp=%0d", n_acc, DEPTH); end
    cycle(1'b1, mk(1'b1, 'h020, 32'h0000_0055), 1'b0, a, p, d);
    checks++; if (a !== 1'b1) begin errors++; $display("FAIL bp_write_accept got=%b exp=1", a); end
    cycle(1'b1, mk(1'b0, 'h020, '0), 1'b1, a, p, d);
    checks++; if (p !== 1'b1) begin errors++; $display("FAIL bp_first_pop got=%b exp=1", p); end
    checks++; if (d !== DW'(0)) begin errors++; $display("FAIL bp_first_data got=%h exp=0", d); end
    checks++; if (a !== 1'b0) begin errors++; $display("FAIL bp_ready_on_pop got=%b exp=0", a); end
    cycle(1'b1, mk(1'b0, 'h020, '0), 1'b1, a, p, d);
    checks++; if (a !== 1'b1) begin errors++; $display("FAIL bp_ready_after_pop got=%b exp=1", a); end
    idle(8, 1'b1);
  endtask

  task automatic test_boundary();
    logic a, p;
    logic [DW-1:0] d;
    int max_cnt = 0;
    for (int i = 0; i < 9; i++) begin
      case (i)
        0, 1, 2: cycle(1'b1, mk(1'b0, 'h100 + i, '0), 1'b0, a, p, d);
        3, 4:    cycle(1'b0, mk(1'b0, 0, '0), 1'b0, a, p, d);
        5: begin
          cycle(1'b1, mk(1'b0, 'h010, '0), 1'b1, a, p, d);
          checks++; if (a !== 1'b1) begin errors++; $display("FAIL edge_accept got=%b exp=1", a); end
          checks++; if (p !== 1'b1) begin errors++; $display("FAIL edge_pop got=%b exp=1", p); end
        end
        6: begin
          cycle(1'b1, mk(1'b0, 'h011, '0), 1'b0, a, p, d);
          checks++; if (a !== 1'b1) begin errors++; $display("FAIL edge_credit_kept got=%b exp=1", a); end
        end
        7: begin
          cycle(1'b1, mk(1'b0, 'h012, '0), 1'b0, a, p, d);
          checks++; if (a !== 1'b0) begin errors++; $display("FAIL edge_exhausted got=%b exp=0", a); end
        end
        default: cycle(1'b0, mk(1'b0, 0, '0), 1'b0, a, p, d);
      endcase
      if (int'(dut.u_fifo.count_o) > max_cnt) max_cnt = int'(dut.u_fifo.count_o);
    end
    checks++; if (max_cnt > DEPTH) begin errors++; $display("FAIL edge_fifo_max got=%0d exp<=%0d", max_cnt, DEPTH); end
    idle(8, 1'b1);
  endtask

  task automatic test_random();
    logic a, p;
    logic [DW-1:0] d;
    logic w;
    int n_rd = 0;
    int n_pop = 0;
    for (int i = 0; i < 32; i++) cycle(1'b1, mk(1'b1, i, DW'($urandom)), 1'b1, a, p, d);
    for (int i = 0; i < 400; i++) begin
      w = ($urandom_range(2) == 0);
      cycle($urandom_range(3) != 0, mk(w, $urandom_range(31), DW'($urandom)),
            $urandom_range(1) == 1, a, p, d);
      if (a && !w) n_rd++;
      if (p) n_pop++;
    end
    for (int i = 0; i < 10; i++) begin
      cycle(1'b0, mk(1'b0, 0, '0), 1'b1, a, p, d);
      if (p) n_pop++;
    end
    checks++; if (n_pop !== n_rd) begin errors++; $display("FAIL rand_balance pops=%0d reads=%0d", n_pop, n_rd); end
    checks++; if (resp_valid !== 1'b0) begin errors++; $display("FAIL rand_drained got=%b exp=0", resp_valid); end
  endtask

  initial begin
    test_reset();
    test_raw();
    test_streaming();
    test_backpressure();
    test_boundary();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
